// File: rtl/cds_sample_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cds_sample_subtractor                                           |
// | Brief    : CDS pair capture, signed difference, FWFT result FIFO with      |
// |            valid/ready drain. Optional frame summing via CDS_ACCUM_EN.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cds_sample_subtractor #(
  parameter int ADC_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter bit DIFF_INVERT = 1'b0,
  parameter int ACC_LOG2    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cds_strobe,
  input  logic                      cds_first,
  input  logic [ADC_W-1:0]          adc_data,
  input  logic                      out_ready,
  input  logic                      clear_flags,
  output logic                      out_valid,
  output logic [ADC_W+ACC_LOG2:0]   out_data,
  output logic [15:0]               frame_count,
  output logic                      seq_err,
  output logic                      overflow
);

  localparam int c_out_w = ADC_W + 1 + ACC_LOG2;
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE       = 1'b0,
    S_HAVE_FIRST = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_latch_s1;
  logic   w_latch_s2;
  logic   w_seq_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_s1  = 1'b0;
    w_latch_s2  = 1'b0;
    w_seq_evt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cds_strobe) begin
          if (cds_first) begin
            w_latch_s1  = 1'b1;
            w_state_nxt = S_HAVE_FIRST;
          end else begin
            w_seq_evt = 1'b1;
          end
        end
      end
      S_HAVE_FIRST: begin
        if (cds_strobe) begin
          // A repeated first sample abandons the pair but keeps the newest word.
          if (cds_first) begin
            w_latch_s1 = 1'b1;
            w_seq_evt  = 1'b1;
          end else begin
            w_latch_s2  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic [ADC_W-1:0] r_s1;
  logic [ADC_W-1:0] r_s2;
  logic             r_push_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_push_pend <= 1'b0;
    end else begin
      if (w_latch_s1) r_s1 <= adc_data;
      if (w_latch_s2) r_s2 <= adc_data;
      r_push_pend <= w_latch_s2;
    end
  end

  logic signed [ADC_W:0]     w_diff;
  logic signed [c_out_w-1:0] w_diff_ext;
  logic signed [c_out_w-1:0] w_push_data;
  logic                      w_push;

  always_comb begin
    if (DIFF_INVERT) w_diff = $signed({1'b0, r_s1}) - $signed({1'b0, r_s2});
    else             w_diff = $signed({1'b0, r_s2}) - $signed({1'b0, r_s1});
    w_diff_ext = c_out_w'(w_diff);
  end

`ifdef CDS_ACCUM_EN
  localparam int c_acc_w = ACC_LOG2 + 1;
  localparam logic [c_acc_w-1:0] c_acc_last = c_acc_w'((1 << ACC_LOG2) - 1);

  logic signed [c_out_w-1:0] r_acc;
  logic [c_acc_w-1:0]        r_acc_cnt;
  logic                      w_acc_done;

  assign w_acc_done  = r_push_pend && (r_acc_cnt == c_acc_last);
  assign w_push      = w_acc_done;
  assign w_push_data = r_acc + w_diff_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else if (r_push_pend) begin
      if (w_acc_done) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else begin
        r_acc     <= r_acc + w_diff_ext;
        r_acc_cnt <= r_acc_cnt + c_acc_w'(1);
      end
    end
  end
`else
  assign w_push      = r_push_pend;
  assign w_push_data = w_diff_ext;
`endif

  logic [c_out_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_out_w-1:0] r_last;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);
  assign w_pop   = !w_empty && out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? r_last : r_mem[r_rd_ptr];

  logic [15:0] r_frame_count;
  logic        r_seq_err;
  logic        r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_seq_err     <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (r_push_pend) r_frame_count <= r_frame_count + 16'd1;
      if (w_seq_evt)        r_seq_err <= 1'b1;
      else if (clear_flags) r_seq_err <= 1'b0;
      if (w_drop)           r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
    end
  end

  assign frame_count = r_frame_count;
  assign seq_err     = r_seq_err;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire
